pzcorebus_packer_data_ram_controller: RTL and testbench

- Sequences the packer data RAM as a first-in, first-out store.
- Owns the write and read pointers and the occupancy count.
- Issues write and read strobes to the RAM macro, whose read data returns READ_LATENCY cycles after the read strobe.
- Presents a valid/ready pop interface through a small output buffer that absorbs in-flight reads, sustaining one word per cycle.
- Sits between the packer's word assembler (push) and the bus request emitter (pop).

---
 rtl/pzcorebus_packer_data_ram_controller.sv | 180 ++++++++++++++++++
 tb/tb_pzcorebus_packer_data_ram_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_packer_data_ram_controller.sv
// pzcorebus_packer_data_ram_controller
// FIFO sequencer for the packer data RAM. It owns the write and read pointers
// and the RAM occupancy. It issues write and read strobes to a RAM macro with
// READ_LATENCY read latency. Read data lands in a small output buffer that
// presents a valid/ready pop interface.
// Optional feature: define PZCOREBUS_PACKER_DATA_RAM_BYPASS_EN to let pushes
// into an otherwise empty block skip the RAM and go straight to the buffer.
module pzcorebus_packer_data_ram_controller #(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int READ_LATENCY  = 2,
    localparam int BUFFER_DEPTH = READ_LATENCY + 1,
    parameter int COUNT_WIDTH   = $clog2(DEPTH + BUFFER_DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_push_valid,
    output logic                     o_push_ready,
    input  logic [DATA_WIDTH-1:0]    i_push_data,
    output logic                     o_pop_valid,
    input  logic                     i_pop_ready,
    output logic [DATA_WIDTH-1:0]    o_pop_data,
    output logic                     o_ram_write_valid,
    output logic [ADDRESS_WIDTH-1:0] o_ram_write_address,
    output logic [DATA_WIDTH-1:0]    o_ram_write_data,
    output logic                     o_ram_read_valid,
    output logic [ADDRESS_WIDTH-1:0] o_ram_read_address,
    input  logic [DATA_WIDTH-1:0]    i_ram_read_data,
    output logic [COUNT_WIDTH-1:0]   o_word_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int RAM_COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam int BUF_COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1);
    localparam int BUF_PTR_WIDTH   = $clog2(BUFFER_DEPTH);

    // RAM side state
    logic [ADDRESS_WIDTH-1:0]   write_ptr;
    logic [ADDRESS_WIDTH-1:0]   read_ptr;
    logic [RAM_COUNT_WIDTH-1:0] ram_count;

    // One bit per outstanding read; the MSB marks the cycle its data is valid
    logic [READ_LATENCY-1:0]    inflight;
    logic [BUF_COUNT_WIDTH-1:0] inflight_count;

    // Output buffer: circular register array
    logic [DATA_WIDTH-1:0]      buffer [BUFFER_DEPTH];
    logic [BUF_PTR_WIDTH-1:0]   head;
    logic [BUF_PTR_WIDTH-1:0]   tail;
    logic [BUF_COUNT_WIDTH-1:0] buffer_count;

    logic                       push_fire;
    logic                       pop_fire;
    logic                       read_return;
    logic                       read_issue;
    logic                       bypass;
    logic                       ram_write;
    logic                       buffer_write;
    logic [DATA_WIDTH-1:0]      buffer_wdata;
    logic [COUNT_WIDTH-1:0]     pending;

    function automatic logic [ADDRESS_WIDTH-1:0] next_address(input logic [ADDRESS_WIDTH-1:0] a);
        return (a == ADDRESS_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [BUF_PTR_WIDTH-1:0] next_slot(input logic [BUF_PTR_WIDTH-1:0] p);
        return (p == BUF_PTR_WIDTH'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Count outstanding reads for the buffer-space reservation
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_count = inflight_count + BUF_COUNT_WIDTH'(inflight[i]);
        end
    end

    assign o_full       = (ram_count == RAM_COUNT_WIDTH'(DEPTH));
    assign o_push_ready = !o_full;
    assign o_pop_valid  = (buffer_count != '0);
    assign o_pop_data   = buffer[head];

    assign push_fire   = i_push_valid && o_push_ready;
    assign pop_fire    = o_pop_valid && i_pop_ready;
    assign read_return = inflight[READ_LATENCY-1];

    // Buffer slots already claimed once this cycle's pop is accounted for.
    // Reserving space at issue time means returning data always has a slot.
    assign pending = COUNT_WIDTH'(buffer_count) + COUNT_WIDTH'(inflight_count)
                   - COUNT_WIDTH'(pop_fire);

    assign read_issue = (ram_count != '0) && (pending < COUNT_WIDTH'(BUFFER_DEPTH)) && !i_clr;

`ifdef PZCOREBUS_PACKER_DATA_RAM_BYPASS_EN
    // Nothing older is in the RAM or in flight, so a direct buffer write keeps order
    assign bypass = (ram_count == '0) && (inflight_count == '0)
                 && (pending < COUNT_WIDTH'(BUFFER_DEPTH));
`else
    assign bypass = 1'b0;
`endif

    assign ram_write    = push_fire && !bypass;
    assign buffer_write = read_return || (push_fire && bypass);
    assign buffer_wdata = read_return ? i_ram_read_data : i_push_data;

    assign o_ram_write_valid   = ram_write;
    assign o_ram_write_address = write_ptr;
    assign o_ram_write_data    = i_push_data;
    assign o_ram_read_valid    = read_issue;
    assign o_ram_read_address  = read_ptr;

    assign o_word_count = COUNT_WIDTH'(ram_count) + COUNT_WIDTH'(inflight_count)
                        + COUNT_WIDTH'(buffer_count);
    assign o_empty      = (o_word_count == '0);

    // RAM pointers and occupancy; a push and an issue in the same cycle cancel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            ram_count <= '0;
        end else if (i_clr) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            ram_count <= '0;
        end else begin
            if (ram_write) begin
                write_ptr <= next_address(write_ptr);
            end
            if (read_issue) begin
                read_ptr <= next_address(read_ptr);
            end
            case ({ram_write, read_issue})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
        end
    end

    // In-flight read tracker; clearing it drops data from reads issued before a flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight <= '0;
        end else if (i_clr) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight << 1) | READ_LATENCY'(read_issue);
        end
    end

    // Output buffer: returning data (or bypassed push) at tail, pop at head
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head         <= '0;
            tail         <= '0;
            buffer_count <= '0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else if (i_clr) begin
            head         <= '0;
            tail         <= '0;
            buffer_count <= '0;
        end else begin
            if (buffer_write) begin
                buffer[tail] <= buffer_wdata;
                tail         <= next_slot(tail);
            end
            if (pop_fire) begin
                head <= next_slot(head);
            end
            buffer_count <= buffer_count + BUF_COUNT_WIDTH'(buffer_write)
                          - BUF_COUNT_WIDTH'(pop_fire);
        end
    end

endmodule

// File: tb/tb_pzcorebus_packer_data_ram_controller.sv
// Scoreboard bench for pzcorebus_packer_data_ram_controller with a behavioural
// RAM macro model. Pushes are recorded at the negative edge; a monitor pops and
// compares whenever a pop fires.
module tb_pzcorebus_packer_data_ram_controller;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int RL    = 2;
    localparam int CW    = 5;
`ifdef PZCOREBUS_PACKER_DATA_RAM_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_data = '0;
    logic          pop_valid;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] pop_data;
    logic          ram_wv;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;
    logic          ram_rv;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_rd;
    logic [CW-1:0] word_count;
    logic          empty;
    logic          full;

    pzcorebus_packer_data_ram_controller #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_push_valid(push_valid), .o_push_ready(push_ready), .i_push_data(push_data),
        .o_pop_valid(pop_valid), .i_pop_ready(pop_ready), .o_pop_data(pop_data),
        .o_ram_write_valid(ram_wv), .o_ram_write_address(ram_wa), .o_ram_write_data(ram_wd),
        .o_ram_read_valid(ram_rv), .o_ram_read_address(ram_ra), .i_ram_read_data(ram_rd),
        .o_word_count(word_count), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro model: data appears RL cycles after the read strobe
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rpipe [RL];
    always @(posedge clk) begin
        if (ram_wv) mem[ram_wa] <= ram_wd;
        rpipe[0] <= ram_rv ? mem[ram_ra] : 32'hDEAD_BEEF;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rd = rpipe[RL-1];

    logic [DW-1:0] exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: scoreboard, address sequencing and stall stability
    logic [AW-1:0] exp_wa = '0;
    logic [AW-1:0] exp_ra = '0;
    bit            stall_chk = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            pop_cnt = 0;
    int            first_pop = -1;
    int            last_pop = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || clr) begin
                exp_wa = '0;
                exp_ra = '0;
                prev_stall = 1'b0;
            end else begin
                if (ram_wv) begin
                    chk("write_addr", ram_wa, exp_wa);
                    exp_wa = exp_wa + 1'b1;
                end
                if (ram_rv) begin
                    chk("read_addr", ram_ra, exp_ra);
                    exp_ra = exp_ra + 1'b1;
                end
                if (push_valid && push_ready) exp_q.push_back(push_data);
                if (stall_chk && prev_stall) begin
                    chk("stall_valid", pop_valid, 1);
                    chk("stall_data", pop_data, prev_data);
                end
                if (pop_valid && pop_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got 0x%0h, expected no word", pop_data);
                    end else begin
                        chk("pop_data", pop_data, exp_q.pop_front());
                    end
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    pop_cnt++;
                end
                prev_stall = pop_valid && !pop_ready;
                prev_data  = pop_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int t;
        t = 0;
        push_valid = 1'b1;
        push_data  = d;
        while (1) begin
            @(negedge clk);
            if (push_ready) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL push_timeout: got no push_ready, expected it within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 || !empty) begin
            step();
            t++;
            if (t > budget) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_drain: got %0d words left, expected 0 within %0d cycles",
                         name, exp_q.size(), budget);
                return;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_push_ready"}, push_ready, 1);
        chk({tag, "_pop_valid"}, pop_valid, 0);
        chk({tag, "_pop_data"}, pop_data, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_ram_wv"}, ram_wv, 0);
        chk({tag, "_ram_rv"}, ram_rv, 0);
        chk({tag, "_ram_wa"}, ram_wa, 0);
        chk({tag, "_ram_ra"}, ram_ra, 0);
    endtask

    bit done = 1'b0;

    initial begin
        int t0;
        int lat;
        int pc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        rst_n = 1'b1;
        step();
        step();
        check_reset("after_reset");

        // Empty-block latency
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        push_data  = 32'hA5A5_0001;
        t0 = cyc;
        step();
        push_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (pop_valid) begin
                lat = cyc - t0;
                break;
            end
            step();
        end
        chk("latency", lat, EXP_LAT);
        chk("latency_data", pop_data, 32'hA5A5_0001);
        wait_drain("latency", 20);

        // Fill to full with the consumer stalled: RAM full plus buffer full
        pop_ready = 1'b0;
        for (int i = 0; i < DEPTH + RL + 1; i++) push_word(i);
        chk("fill_full", full, 1);
        chk("fill_push_ready", push_ready, 0);
        chk("fill_word_count", word_count, DEPTH + RL + 1);
        chk("fill_empty", empty, 0);
        repeat (3) step();
        chk("fill_hold_push_ready", push_ready, 0);
        chk("fill_hold_word_count", word_count, DEPTH + RL + 1);
        pop_ready = 1'b1;
        wait_drain("fill", 100);
        chk("fill_after_full", full, 0);
        chk("fill_after_push_ready", push_ready, 1);

        // Streaming: one word per cycle, addresses wrap repeatedly
        pop_cnt = 0;
        first_pop = -1;
        for (int i = 0; i < 100; i++) push_word($urandom);
        wait_drain("stream", 50);
        chk("stream_count", pop_cnt, 100);
        chk("stream_span", last_pop - first_pop, 99);

        // Random consumer stalls
        stall_chk = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) push_word($urandom);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    pop_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        pop_ready = 1'b1;
        wait_drain("stall", 400);
        stall_chk = 1'b0;

        // Flush with reads in flight
        pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h0000_0011 + i);
        chk("clr_before_count", word_count, 4);
        clr = 1'b1;
        exp_q.delete();
        step();
        clr = 1'b0;
        chk("clr_word_count", word_count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_pop_valid", pop_valid, 0);
        repeat (4) step();
        chk("clr_late_pop_valid", pop_valid, 0);
        chk("clr_late_word_count", word_count, 0);
        pc = pop_cnt;
        pop_ready = 1'b1;
        push_word(32'hC0FF_EE01);
        wait_drain("clr", 20);
        chk("clr_first_pop", pop_cnt - pc, 1);

        // Asynchronous reset mid-stream
        pop_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h0000_0100 + i);
        chk("rst_before_count", word_count, 8);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        check_reset("mid_after");
        pc = pop_cnt;
        pop_ready = 1'b1;
        push_word(32'h0000_1234);
        wait_drain("rst", 20);
        chk("rst_fresh_pop", pop_cnt - pc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected it before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
